sodor_mem_port_arbiter: RTL
===========================

// Module: sodor_mem_port_arbiter
// PURPOSE
// - Shares the single core-side request port of the scratchpad/master request router between the
//   instruction-fetch client (C0) and the data-memory client (C1) of the 2-stage Sodor core.
// - At most one request is outstanding. The block registers the owner and the address of that
//   request, drives the router's response-address select, and returns the response to the owner.
// - Includes anti-starvation for fetch and a response timeout.
// PARAMETERS
// - STARVE_LIMIT   4    consecutive C1 grants allowed while C0 is waiting before C0 is forced (>=1)
// - TIMEOUT_CYCLES 255  cycles in WAIT with no mem_resp_valid before an error completion (>=2)
// - CNT_W          8    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
// - clock           in   1   single clock; all state updates on the rising edge
// - reset           in   1   asynchronous, active-low reset
// - cN_req_valid    in   1   client N request valid (N = 0 fetch, 1 data)
// - cN_req_ready    out  1   client N request accepted this cycle
// - cN_req_addr     in   32  byte address
// - cN_req_data     in   32  store data
// - cN_req_fcn      in   1   0 = load, 1 = store
// - cN_req_typ      in   3   access size/type, passed through unchanged
// - cN_resp_valid   out  1   one-cycle response pulse to client N
// - cN_resp_data    out  32  response data
// - cN_resp_err     out  1   qualifies cN_resp_valid: request timed out
// - mem_req_valid   out  1   request to router core port
// - mem_req_addr / _data / _fcn / _typ   out  32/32/1/3   muxed request fields
// - mem_resp_valid  in   1   router response valid
// - mem_resp_data   in   32  router response data
// - mem_resp_addr   out  32  registered address of the outstanding request (router respAddress)
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; owner=0; starve_cnt=0; tmo_cnt=0;
//   mem_resp_addr=0; all valid/ready/err outputs 0.
// - FSM IDLE:
//   - Arbitrate combinationally: grant C1 if c1_req_valid, unless
//     (c0_req_valid && starve_cnt==STARVE_LIMIT), in which case grant C0; otherwise grant C0 if valid.
//   - On a grant: mem_req_valid=1; fields muxed from the winner; the winner's req_ready=1 in the
//     same cycle; latch owner and addr into mem_resp_addr; go to WAIT; tmo_cnt=0.
//   - No request: all outputs quiet; data outputs hold last value.
// - FSM WAIT:
//   - Both req_ready=0 and mem_req_valid=0.
//   - tmo_cnt increments every cycle.
//   - mem_resp_valid: next cycle is a registered pulse, owner's resp_valid=1 with resp_data=mem_resp_data,
//     err=0; then IDLE. Response latency to client = mem latency + 1.
//   - tmo_cnt==TIMEOUT_CYCLES-1 with no response: the owner gets resp_valid=1, err=1, data=0 next
//     cycle; then IDLE. A stray mem_resp_valid in IDLE is dropped.
// - Back-to-back: a new grant is possible in the cycle the response pulse is presented. Peak throughput
//   is one request per (mem latency + 1) cycles.
// - Starvation counter: on a C1 grant while c0_req_valid, increment, saturating at STARVE_LIMIT;
//   on a C0 grant, or when C0 is not waiting, clear to 0.
// - Simultaneous mem_resp_valid and timeout edge: the response wins (err=0).
// - Reset mid-WAIT: the outstanding request is abandoned; no response pulse.
// - Requests are never reordered or split; addresses are not range-checked (the router decides).
// STRUCTURE
// - Shared package sodor_mem_pkg: FCN_LD/FCN_ST, typ encodings, state enum {IDLE, WAIT, RESP},
//   mem request struct {addr, data, fcn, typ}.
// - One natural sub-module: sodor_prio_starve_arb. It holds the 2-way fixed-priority grant and the
//   saturating starvation counter. The FSM, timeout and response steering stay in the top.
// TESTING
// - Lone C0 load addr 0x8000_0010, mem replies data 0xCAFE_F00D after 3 cycles
//   -> c0_resp_valid pulse 4 cycles after the grant; data match; err=0; c1 quiet.
// - C0 and C1 both held valid, STARVE_LIMIT=4
//   -> grant order C1,C1,C1,C1,C0,C1,... and C0 is never starved.
// - C1 store while C0 idle
//   -> mem_resp_addr equals the C1 addr from the grant cycle until the next grant;
//      c0_req_ready stays 0 throughout WAIT.
// - No mem response, TIMEOUT_CYCLES=8
//   -> owner sees resp_valid=1, err=1, data=0 eight cycles after entering WAIT; the FSM then
//      accepts a new request.
// - Response arrives on the cycle tmo_cnt hits the limit -> normal response, err=0.
// - Reset asserted mid-WAIT, then released -> all outputs 0; the late mem_resp_valid is ignored;
//   the next request is granted normally.

Source files
------------

// File: rtl/sodor_mem_pkg.sv
// Shared types and encodings for the Sodor core-side memory request path.
package sodor_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TYP_W  = 3;

  localparam logic FCN_LD = 1'b0;
  localparam logic FCN_ST = 1'b1;

  localparam logic [TYP_W-1:0] MT_X  = 3'd0;
  localparam logic [TYP_W-1:0] MT_B  = 3'd1;
  localparam logic [TYP_W-1:0] MT_H  = 3'd2;
  localparam logic [TYP_W-1:0] MT_W  = 3'd3;
  localparam logic [TYP_W-1:0] MT_D  = 3'd4;
  localparam logic [TYP_W-1:0] MT_BU = 3'd5;
  localparam logic [TYP_W-1:0] MT_HU = 3'd6;
  localparam logic [TYP_W-1:0] MT_WU = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arbState_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              fcn;
    logic [TYP_W-1:0]  typ;
  } memReq_t;

  function automatic memReq_t packReq(input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data,
                                      input logic              fcn,
                                      input logic [TYP_W-1:0]  typ);
    memReq_t r;
    r.addr = addr;
    r.data = data;
    r.fcn  = fcn;
    r.typ  = typ;
    return r;
  endfunction

endpackage

// File: rtl/sodor_prio_starve_arb.sv
// Two-way grant: data client (req1) wins by default, fetch (req0) is forced
// once it has watched STARVE_LIMIT consecutive data grants.
module sodor_prio_starve_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic arbEn,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starveCnt;
  logic          forceReq0;

  function automatic logic [SW-1:0] satInc(input logic [SW-1:0] cnt);
    return (cnt == LIMIT) ? cnt : cnt + 1'b1;
  endfunction

  assign forceReq0 = req0 && (starveCnt == LIMIT);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (arbEn) begin
      if (req1 && !forceReq0) grant1 = 1'b1;
      else if (req0)          grant0 = 1'b1;
    end
  end

  // The count only tracks a continuously waiting fetch client.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                starveCnt <= '0;
    else if (!req0 || grant0)  starveCnt <= '0;
    else if (grant1)           starveCnt <= satInc(starveCnt);
  end

endmodule

// File: rtl/sodor_mem_port_arbiter.sv
// Shares the router core port between fetch (C0) and data (C1) with one
// outstanding request, a fetch anti-starvation rule and a response timeout.
module sodor_mem_port_arbiter
  import sodor_mem_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c0_req_valid,
  output logic              c0_req_ready,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_data,
  input  logic              c0_req_fcn,
  input  logic [TYP_W-1:0]  c0_req_typ,
  output logic              c0_resp_valid,
  output logic [DATA_W-1:0] c0_resp_data,
  output logic              c0_resp_err,
  input  logic              c1_req_valid,
  output logic              c1_req_ready,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_data,
  input  logic              c1_req_fcn,
  input  logic [TYP_W-1:0]  c1_req_typ,
  output logic              c1_resp_valid,
  output logic [DATA_W-1:0] c1_resp_data,
  output logic              c1_resp_err,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_fcn,
  output logic [TYP_W-1:0]  mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [ADDR_W-1:0] mem_resp_addr
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arbState_e         state;
  arbState_e         nextState;
  logic              owner;
  logic [CNT_W-1:0]  tmoCnt;
  logic [DATA_W-1:0] respData_p1;
  logic              respErr_p1;
  memReq_t           c0Req;
  memReq_t           c1Req;
  memReq_t           winReq;
  memReq_t           lastReq;
  logic              arbEn;
  logic              grant0;
  logic              grant1;
  logic              anyGrant;
  logic              tmoHit;
  logic              respValid;

  assign c0Req    = packReq(c0_req_addr, c0_req_data, c0_req_fcn, c0_req_typ);
  assign c1Req    = packReq(c1_req_addr, c1_req_data, c1_req_fcn, c1_req_typ);
  // RESP presents the pulse and may already grant the next request.
  assign arbEn    = (state != WAIT);
  assign anyGrant = grant0 | grant1;
  assign winReq   = grant1 ? c1Req : c0Req;
  assign tmoHit   = (tmoCnt == TMO_LAST);

  sodor_prio_starve_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) uArb (
    .clock (clock),
    .reset (reset),
    .arbEn (arbEn),
    .req0  (c0_req_valid),
    .req1  (c1_req_valid),
    .grant0(grant0),
    .grant1(grant1)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, RESP: nextState = anyGrant ? WAIT : IDLE;
      WAIT:       if (mem_resp_valid || tmoHit) nextState = RESP;
      default:    nextState = IDLE;
    endcase
  end

  // p0: grant cycle captures owner and the response address for the router
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner         <= 1'b0;
      mem_resp_addr <= '0;
      lastReq       <= '0;
      tmoCnt        <= '0;
    end else if (anyGrant) begin
      owner         <= grant1;
      mem_resp_addr <= winReq.addr;
      lastReq       <= winReq;
      tmoCnt        <= '0;
    end else if (state == WAIT) begin
      tmoCnt        <= tmoCnt + 1'b1;
    end
  end

  // p1: response registered one cycle after the router answers or times out;
  // a real response beats a coincident timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      respData_p1 <= '0;
      respErr_p1  <= 1'b0;
    end else if (state == WAIT) begin
      if (mem_resp_valid) begin
        respData_p1 <= mem_resp_data;
        respErr_p1  <= 1'b0;
      end else if (tmoHit) begin
        respData_p1 <= '0;
        respErr_p1  <= 1'b1;
      end
    end
  end

  always_comb begin
    c0_req_ready  = grant0;
    c1_req_ready  = grant1;
    mem_req_valid = anyGrant;
    {mem_req_addr, mem_req_data, mem_req_fcn, mem_req_typ} = anyGrant ? winReq : lastReq;
    respValid     = (state == RESP);
    c0_resp_valid = respValid && !owner;
    c1_resp_valid = respValid &&  owner;
    c0_resp_data  = respData_p1;
    c1_resp_data  = respData_p1;
    c0_resp_err   = c0_resp_valid && respErr_p1;
    c1_resp_err   = c1_resp_valid && respErr_p1;
  end

endmodule
